// File: rtl/core_ex_alu_arb_pkg.sv
// Shared constants, ALU opcode encoding and helpers for the EX-stage ALU arbiter.
// The one-hot ALU instruction bus sets bit <alu_op_e> for the selected operation.
package core_ex_alu_arb_pkg;

    localparam int   CORE_XLEN            = 32;
    localparam int   CORE_ALU_INST_WIDTH  = 12;
    localparam int   CORE_ALU_ARB_TAG_W   = 4;
    localparam logic CORE_ALU_ARB_ID_MAIN = 1'b0;
    localparam logic CORE_ALU_ARB_ID_SIDE = 1'b1;
    localparam int   CORE_ALU_ARB_STAT_W  = 16;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_ADDI  = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    localparam int ALU_NUM_OPS = 12;

    function automatic logic [CORE_ALU_ARB_STAT_W-1:0] sat_inc(
        input logic [CORE_ALU_ARB_STAT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/core_ex_alu_arb_alu.sv
// core_ex_alu: combinational EX-stage ALU driven by a one-hot instruction bus.
// A bus with no bit set yields result 0; zero tracks the result, less is signed rs1 < rs2.
module core_ex_alu
    import core_ex_alu_arb_pkg::*;
#(
    parameter int XLEN   = CORE_XLEN,
    parameter int INST_W = CORE_ALU_INST_WIDTH
) (
    input  logic [INST_W-1:0] inst_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   imm_i,
    output logic [XLEN-1:0]   result_o,
    output logic              zero_o,
    output logic              less_o
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    logic            slt;
    logic            sltu;
    logic [XLEN-1:0] res;

    assign shamt = rs2_i[SH_W-1:0];
    assign slt   = $signed(rs1_i) < $signed(rs2_i);
    assign sltu  = rs1_i < rs2_i;

    // AND-OR mux over the one-hot select keeps the datapath free of priority chains.
    always_comb begin
        res = '0;
        if (inst_i[ALU_ADD])   res = res | (rs1_i + rs2_i);
        if (inst_i[ALU_SUB])   res = res | (rs1_i - rs2_i);
        if (inst_i[ALU_AND])   res = res | (rs1_i & rs2_i);
        if (inst_i[ALU_OR])    res = res | (rs1_i | rs2_i);
        if (inst_i[ALU_XOR])   res = res | (rs1_i ^ rs2_i);
        if (inst_i[ALU_SLL])   res = res | (rs1_i << shamt);
        if (inst_i[ALU_SRL])   res = res | (rs1_i >> shamt);
        if (inst_i[ALU_SRA])   res = res | XLEN'($signed(rs1_i) >>> shamt);
        if (inst_i[ALU_SLT])   res = res | XLEN'(slt);
        if (inst_i[ALU_SLTU])  res = res | XLEN'(sltu);
        if (inst_i[ALU_ADDI])  res = res | (rs1_i + imm_i);
        if (inst_i[ALU_AUIPC]) res = res | (pc_i + imm_i);
    end

    assign result_o = res;
    assign zero_o   = (res == '0);
    assign less_o   = slt;

endmodule

// File: rtl/core_ex_alu_arb.sv
// Shares one core_ex_alu between the main issue pipe (req0) and the branch/AGU pipe (req1),
// with a one-deep registered response slot, flush, and a saturating conflict counter.
module core_ex_alu_arb
    import core_ex_alu_arb_pkg::*;
#(
    parameter int XLEN       = CORE_XLEN,
    parameter int INST_W     = CORE_ALU_INST_WIDTH,
    parameter int TAG_W      = CORE_ALU_ARB_TAG_W,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           req0_valid_i,
    output logic                           req0_ready_o,
    input  logic [INST_W-1:0]              req0_inst_i,
    input  logic [XLEN-1:0]                req0_rs1_i,
    input  logic [XLEN-1:0]                req0_rs2_i,
    input  logic [XLEN-1:0]                req0_pc_i,
    input  logic [XLEN-1:0]                req0_imm_i,
    input  logic [TAG_W-1:0]               req0_tag_i,
    input  logic                           req1_valid_i,
    output logic                           req1_ready_o,
    input  logic [INST_W-1:0]              req1_inst_i,
    input  logic [XLEN-1:0]                req1_rs1_i,
    input  logic [XLEN-1:0]                req1_rs2_i,
    input  logic [XLEN-1:0]                req1_pc_i,
    input  logic [XLEN-1:0]                req1_imm_i,
    input  logic [TAG_W-1:0]               req1_tag_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic                           rsp_id_o,
    output logic [TAG_W-1:0]               rsp_tag_o,
    output logic [XLEN-1:0]                rsp_result_o,
    output logic                           rsp_zero_o,
    output logic                           rsp_less_o,
    output logic [CORE_ALU_ARB_STAT_W-1:0] stat_conflict_o
);
    localparam int STAT_W = CORE_ALU_ARB_STAT_W;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [TAG_W-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  result;
        logic             zero;
        logic             less;
    } rsp_t;

    req_t              req0, req1, sel;
    rsp_t              rsp_q, rsp_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              last_gnt_q, last_gnt_d;
    logic [STAT_W-1:0] stat_q, stat_d;
    logic              can_acc, both, gnt0, gnt1, acc;
    logic [XLEN-1:0]   alu_result;
    logic              alu_zero, alu_less;

    assign req0 = '{inst: req0_inst_i, rs1: req0_rs1_i, rs2: req0_rs2_i,
                    pc: req0_pc_i, imm: req0_imm_i, tag: req0_tag_i};
    assign req1 = '{inst: req1_inst_i, rs1: req1_rs1_i, rs2: req1_rs2_i,
                    pc: req1_pc_i, imm: req1_imm_i, tag: req1_tag_i};

    assign can_acc = !rst_i && !flush_i && (!rsp_valid_q || rsp_ready_i);
    assign both    = req0_valid_i && req1_valid_i;

    // On a tie the requester that did not win last goes first, unless req0 is pinned.
    assign gnt0 = req0_valid_i &&
                  (!req1_valid_i || FIXED_PRIO || (last_gnt_q == CORE_ALU_ARB_ID_SIDE));
    assign gnt1 = req1_valid_i && !gnt0;

    assign req0_ready_o = gnt0 && can_acc;
    assign req1_ready_o = gnt1 && can_acc;
    assign acc          = req0_ready_o || req1_ready_o;

    assign sel = ({$bits(req_t){gnt0}} & req0) | ({$bits(req_t){gnt1}} & req1);

    core_ex_alu #(
        .XLEN   (XLEN),
        .INST_W (INST_W)
    ) u_alu (
        .inst_i   (sel.inst),
        .rs1_i    (sel.rs1),
        .rs2_i    (sel.rs2),
        .pc_i     (sel.pc),
        .imm_i    (sel.imm),
        .result_o (alu_result),
        .zero_o   (alu_zero),
        .less_o   (alu_less)
    );

    always_comb begin
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready_i && !flush_i;
        last_gnt_d  = last_gnt_q;
        stat_d      = stat_q;
        if (acc) begin
            rsp_valid_d = 1'b1;
            rsp_d       = '{id: gnt1 ? CORE_ALU_ARB_ID_SIDE : CORE_ALU_ARB_ID_MAIN,
                            tag: sel.tag, result: alu_result,
                            zero: alu_zero, less: alu_less};
            last_gnt_d  = gnt1;
        end
        if (both && can_acc) stat_d = sat_inc(stat_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            last_gnt_q  <= CORE_ALU_ARB_ID_SIDE;
            stat_q      <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            last_gnt_q  <= last_gnt_d;
            stat_q      <= stat_d;
        end
    end

    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_id_o        = rsp_q.id;
    assign rsp_tag_o       = rsp_q.tag;
    assign rsp_result_o    = rsp_q.result;
    assign rsp_zero_o      = rsp_q.zero;
    assign rsp_less_o      = rsp_q.less;
    assign stat_conflict_o = stat_q;

endmodule
